// File: rtl/frame_update_if.sv
// frame_update_if: signal bundle between the frame update scheduler, the VGA timing block and the game-logic clients.
interface frame_update_if #(
    parameter int N_CLIENT = 4,
    parameter int FCNT_W   = 16
);
    logic                vblnk;
    logic [N_CLIENT-1:0] en;
    logic [N_CLIENT-1:0] upd_done;
    logic                clr_err;
    logic [N_CLIENT-1:0] upd_req;
    logic                busy;
    logic                frame_done;
    logic [FCNT_W-1:0]   frame_cnt;
    logic                overrun;
    logic [N_CLIENT-1:0] timeout_err;
    modport master (
        input  vblnk, en, upd_done, clr_err,
        output upd_req, busy, frame_done, frame_cnt, overrun, timeout_err
    );
    modport slave (
        output vblnk, en, upd_done, clr_err,
        input  upd_req, busy, frame_done, frame_cnt, overrun, timeout_err
    );
endinterface

// File: rtl/frame_update_scheduler.sv
// frame_update_scheduler: grants per-frame update slots to enabled clients in index order during vertical blanking,
// with per-slot timeout and overrun detection when blanking ends early.
module frame_update_scheduler #(
    parameter int N_CLIENT = 4,
    parameter int TIMEOUT  = 4096,
    parameter int TMR_W    = 13,
    parameter int FCNT_W   = 16
) (
    input  logic           i_pclk,
    input  logic           i_rst_n,
    frame_update_if.master bus
);
    localparam int IDX_W = N_CLIENT > 1 ? $clog2(N_CLIENT) : 1;
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    state_t              r_state;
    logic                r_vblnk_q, r_armed, r_busy, r_frame_done, r_overrun;
    logic [N_CLIENT-1:0] r_en_lat, r_upd_req, r_timeout_err;
    logic [IDX_W-1:0]    r_idx;
    logic [TMR_W-1:0]    r_timer;
    logic [FCNT_W-1:0]   r_frame_cnt;
    logic                w_rise, w_done, w_tmo, w_first_ok, w_next_ok;
    logic [IDX_W-1:0]    w_first, w_next;

    // r_armed blocks a false rise when vblnk is already high as reset releases
    assign w_rise = bus.vblnk & ~r_vblnk_q & r_armed;
    assign w_done = bus.upd_done[r_idx];
    assign w_tmo  = r_timer == TMR_W'(TIMEOUT - 1);

    always_comb begin
        w_first_ok = 1'b0;
        w_first    = '0;
        w_next_ok  = 1'b0;
        w_next     = '0;
        for (int i = N_CLIENT - 1; i >= 0; i--) begin
            if (bus.en[i]) begin
                w_first_ok = 1'b1;
                w_first    = IDX_W'(i);
            end
            if (r_en_lat[i] && i > int'(r_idx)) begin
                w_next_ok = 1'b1;
                w_next    = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge i_pclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= IDLE;
            r_vblnk_q     <= 1'b0;
            r_armed       <= 1'b0;
            r_upd_req     <= '0;
            r_busy        <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_cnt   <= '0;
            r_overrun     <= 1'b0;
            r_timeout_err <= '0;
            r_timer       <= '0;
            r_en_lat      <= '0;
            r_idx         <= '0;
        end else begin
            r_vblnk_q    <= bus.vblnk;
            r_armed      <= r_armed | ~bus.vblnk;
            r_frame_done <= 1'b0;
            if (bus.clr_err) begin
                r_overrun     <= 1'b0;
                r_timeout_err <= '0;
            end
            case (r_state)
                IDLE: if (w_rise) begin
                    r_frame_cnt <= r_frame_cnt + FCNT_W'(1);
                    r_en_lat    <= bus.en;
                    r_idx       <= w_first;
                    r_timer     <= '0;
                    if (w_first_ok) begin
                        r_state   <= WAIT;
                        r_upd_req <= N_CLIENT'(1) << w_first;
                        r_busy    <= 1'b1;
                    end else begin
                        r_state      <= DONE;
                        r_frame_done <= 1'b1;
                    end
                end
                WAIT: if (!bus.vblnk) begin
                    r_state   <= IDLE;
                    r_upd_req <= '0;
                    r_busy    <= 1'b0;
                    r_overrun <= 1'b1;
                    r_timer   <= '0;
                end else if (w_done || w_tmo) begin
                    r_timer <= '0;
                    if (!w_done)
                        r_timeout_err[r_idx] <= 1'b1;
                    if (w_next_ok) begin
                        r_idx     <= w_next;
                        r_upd_req <= N_CLIENT'(1) << w_next;
                    end else begin
                        r_state      <= DONE;
                        r_upd_req    <= '0;
                        r_busy       <= 1'b0;
                        r_frame_done <= 1'b1;
                    end
                end else begin
                    r_timer <= r_timer + TMR_W'(1);
                end
                default: if (!bus.vblnk) r_state <= IDLE;
            endcase
        end
    end

    assign bus.upd_req     = r_upd_req;
    assign bus.busy        = r_busy;
    assign bus.frame_done  = r_frame_done;
    assign bus.frame_cnt   = r_frame_cnt;
    assign bus.overrun     = r_overrun;
    assign bus.timeout_err = r_timeout_err;
endmodule

// File: tb/tb_frame_update_scheduler.sv
// tb_frame_update_scheduler: randomized frames checked cycle by cycle against a per-frame slot schedule model.
module tb_frame_update_scheduler;
    localparam int N = 4, TMO = 4096, FW = 12, NEVER = 1 << 20;
    logic clk = 1'b0, rst_n = 1'b0;
    frame_update_if #(.N_CLIENT(N), .FCNT_W(FW)) bus ();
    frame_update_scheduler #(.N_CLIENT(N), .TIMEOUT(TMO), .TMR_W(13), .FCNT_W(FW)) dut (
        .i_pclk (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );
    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int lat [N];
    int cnt [N];
    int gcnt [N];
    int fdcnt;
    bit rand_clr;
    // model: a frame is a list of slots [st, st+hold) counted in edges after the rise edge
    bit prev_v, live;
    int k, t_total;
    int st [N];
    int hold [N];
    bit to [N];
    logic [N-1:0] m_en, m_terr;
    logic m_ovr;
    logic [FW-1:0] m_fcnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        prev_v = 1'b1;
        live = 1'b0;
        k = 0;
        t_total = 0;
        m_en = '0;
        m_terr = '0;
        m_ovr = 1'b0;
        m_fcnt = '0;
    endtask

    task automatic model_edge();
        if (bus.clr_err) begin
            m_ovr = 1'b0;
            m_terr = '0;
        end
        if (bus.vblnk && !prev_v) begin
            m_fcnt++;
            m_en = bus.en;
            k = 0;
            live = 1'b1;
            t_total = 0;
            for (int i = 0; i < N; i++) if (m_en[i]) begin
                st[i] = t_total;
                hold[i] = (lat[i] + 1 < TMO) ? lat[i] + 1 : TMO;
                to[i] = lat[i] + 1 > TMO;
                t_total += hold[i];
            end
        end else if (live) begin
            k++;
            if (k > t_total) live = 1'b0;
            else if (!bus.vblnk) begin
                live = 1'b0;
                m_ovr = 1'b1;
            end else
                for (int i = 0; i < N; i++)
                    if (m_en[i] && to[i] && k == st[i] + hold[i]) m_terr[i] = 1'b1;
        end
        prev_v = bus.vblnk;
    endtask

    task automatic tick();
        logic [N-1:0] er;
        @(posedge clk);
        @(negedge clk);
        model_edge();
        er = '0;
        if (live)
            for (int i = 0; i < N; i++)
                if (m_en[i] && k >= st[i] && k < st[i] + hold[i]) er[i] = 1'b1;
        check("upd_req", bus.upd_req, er);
        check("busy", bus.busy, er != 0);
        check("frame_done", bus.frame_done, live && k == t_total);
        check("frame_cnt", bus.frame_cnt, m_fcnt);
        check("overrun", bus.overrun, m_ovr);
        check("timeout_err", bus.timeout_err, m_terr);
        if (bus.frame_done) fdcnt++;
        bus.clr_err = rand_clr && $urandom_range(15) == 0;
        for (int i = 0; i < N; i++) begin
            if (bus.upd_req[i]) begin
                cnt[i]++;
                gcnt[i]++;
            end else cnt[i] = 0;
            bus.upd_done[i] = bus.upd_req[i] ? (cnt[i] >= lat[i] + 1) : 1'($urandom_range(1));
        end
    endtask

    task automatic run_frame(input logic [N-1:0] e, input logic [N-1:0] e_mid, input int hi, input int lo);
        for (int i = 0; i < N; i++) gcnt[i] = 0;
        fdcnt = 0;
        bus.en = e;
        bus.vblnk = 1'b1;
        tick();
        bus.en = e_mid;
        for (int c = 1; c < hi; c++) tick();
        bus.vblnk = 1'b0;
        for (int c = 0; c < lo; c++) tick();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_req"}, bus.upd_req, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_fdone"}, bus.frame_done, 0);
        check({tag, "_fcnt"}, bus.frame_cnt, 0);
        check({tag, "_ovr"}, bus.overrun, 0);
        check({tag, "_terr"}, bus.timeout_err, 0);
    endtask

    initial begin
        logic [FW-1:0] f0;
        bus.vblnk = 1'b0;
        bus.en = '0;
        bus.upd_done = '0;
        bus.clr_err = 1'b0;
        rand_clr = 1'b0;
        for (int i = 0; i < N; i++) begin
            cnt[i] = 0;
            lat[i] = 10;
        end
        model_reset();
        repeat (3) @(negedge clk);
        check_zero("rst");
        rst_n = 1'b1;
        model_reset();
        tick();
        tick();
        // all four clients answer 10 cycles after their grant
        run_frame(4'b1111, 4'b1111, 60, 5);
        for (int i = 0; i < N; i++) check("t1_slot_len", gcnt[i], 11);
        check("t1_fdone_cnt", fdcnt, 1);
        check("t1_fcnt", bus.frame_cnt, 1);
        check("t1_terr", bus.timeout_err, 0);
        // mask widens mid-frame, must not add clients
        lat = '{3, 20, 7, 20};
        run_frame(4'b0101, 4'b1111, 40, 4);
        check("t2_c0", gcnt[0], 4);
        check("t2_c1", gcnt[1], 0);
        check("t2_c2", gcnt[2], 8);
        check("t2_c3", gcnt[3], 0);
        // client 0 silent: full timeout, then client 1
        lat = '{NEVER, 5, 5, 5};
        run_frame(4'b0011, 4'b0011, 4200, 4);
        check("t3_slot_len", gcnt[0], TMO);
        check("t3_terr", bus.timeout_err, 4'b0001);
        check("t3_fdone_cnt", fdcnt, 1);
        bus.clr_err = 1'b1;
        tick();
        check("t3_clr", bus.timeout_err, 0);
        // blanking too short: overrun, then a clean restart
        lat = '{NEVER, NEVER, NEVER, NEVER};
        f0 = bus.frame_cnt;
        run_frame(4'b0001, 4'b0001, 50, 5);
        check("t4_slot_len", gcnt[0], 50);
        check("t4_ovr", bus.overrun, 1);
        check("t4_fdone_cnt", fdcnt, 0);
        lat = '{3, 3, 3, 3};
        run_frame(4'b0001, 4'b0001, 20, 3);
        check("t4_restart", gcnt[0], 4);
        check("t4_fcnt", bus.frame_cnt, FW'(f0 + 2));
        // empty frames, long enough for the counter to wrap
        f0 = bus.frame_cnt;
        for (int f = 0; f < (1 << FW); f++) run_frame(4'b0000, 4'b1111, 1, 1);
        check("t5_fdone_cnt", fdcnt, 1);
        check("t5_no_grant", gcnt[0] + gcnt[1] + gcnt[2] + gcnt[3], 0);
        check("t5_wrap", bus.frame_cnt, f0);
        // async reset in the middle of client 1's slot
        lat = '{NEVER, NEVER, NEVER, NEVER};
        bus.en = 4'b0010;
        bus.vblnk = 1'b1;
        repeat (5) tick();
        check("t6_pre", bus.upd_req, 4'b0010);
        #2 rst_n = 1'b0;
        #1 check_zero("t6_async");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < N; i++) gcnt[i] = 0;
        repeat (8) tick();
        check("t6_no_grant", gcnt[1], 0);
        bus.vblnk = 1'b0;
        tick();
        lat = '{2, 2, 2, 2};
        run_frame(4'b0010, 4'b0010, 10, 2);
        check("t6_fresh", gcnt[1], 3);
        // random frames, masks, latencies, blanking lengths and clears
        rand_clr = 1'b1;
        for (int f = 0; f < 150; f++) begin
            for (int i = 0; i < N; i++) lat[i] = $urandom_range(0, 30);
            run_frame(N'($urandom), N'($urandom), $urandom_range(1, 160), $urandom_range(1, 6));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/frame_update_scheduler.md
Name: frame_update_scheduler

Overview:
- Sequences per-frame game-state updates (ball, paddles, score, etc.) inside the vertical blanking window of the 800x600@60 timing generator.
- On each vblnk rising edge, grants update slots to enabled clients one at a time, in fixed index order, using a req/done handshake.
- Flags per-client timeouts, and flags overrun if blanking ends before the sequence completes.
- Sits between the VGA timing block and the game-logic modules; the timing block is its only time reference.

Parameters:
- N_CLIENT, 4, number of update clients; index 0 is served first.
- TIMEOUT, 4096, max pclk cycles a client may hold its slot, 2..2^TMR_W-1.
- TMR_W, 13, width of the slot timer.
- FCNT_W, 16, width of the frame counter.

Ports:
- pclk  in  1  pixel clock, 40 MHz, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- vblnk  in  1  vertical blank from the timing block, high for vcount >= 600.
- en  in  N_CLIENT  client enable mask, sampled only at vblnk rise.
- upd_done  in  N_CLIENT  client completion, one bit per client, level or pulse.
- clr_err  in  1  synchronous clear of the sticky error flags.
- upd_req  out  N_CLIENT  one-hot (or zero) slot grant, registered.
- busy  out  1  high in WAIT.
- frame_done  out  1  one-cycle pulse when all enabled clients have finished.
- frame_cnt  out  FCNT_W  count of vblnk rises, wraps to 0.
- overrun  out  1  sticky; blanking ended while a slot was active.
- timeout_err  out  N_CLIENT  sticky per-client timeout flags.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, vblnk_q=0, upd_req=0, busy=0, frame_done=0.
  - frame_cnt=0, overrun=0, timeout_err=0, timer=0, en_lat=0.
- Edge detect: vblnk_q is vblnk registered; rise = vblnk & ~vblnk_q. If vblnk is high out of reset, no rise is seen until it goes low then high again.
- IDLE:
  - On rise: frame_cnt += 1 (mod 2^FCNT_W) and en_lat <= en.
  - If en != 0: go to WAIT with upd_req = one-hot of the lowest set bit of en and timer=0. upd_req is visible the cycle after vblnk is first high.
  - If en == 0: pulse frame_done the next cycle and go to DONE.
- WAIT (current index idx, upd_req[idx]=1):
  - timer increments each cycle.
  - Advance condition: upd_done[idx]=1, or timer==TIMEOUT-1. A timeout sets timeout_err[idx]. If both occur in the same cycle, done wins and no error is set.
  - On advance: idx = next set bit of en_lat above idx, with upd_req switching the following cycle and timer=0. There is no idle gap between clients.
  - If no higher bit is set: upd_req=0, frame_done pulses 1 cycle, go to DONE.
  - upd_done bits other than idx are ignored.
  - If vblnk=0 in WAIT: upd_req=0 the next cycle, overrun<=1, go to IDLE without frame_done. The abort has priority over a same-cycle done or timeout, and no timeout_err is set in that cycle.
- DONE: hold until vblnk=0, then go to IDLE. A rise cannot occur in DONE.
- Sticky flags: clr_err=1 clears overrun and timeout_err. A set event in the same cycle wins over the clear.
- en changes mid-frame have no effect until the next rise.
- Reset asserted mid-sequence drops upd_req immediately (async).
- Blanking window at nominal timing is 28 lines x 1056 = 29568 cycles, which covers N_CLIENT*TIMEOUT at default values.

Test Plan:
1. Reset, en=4'b1111, each client returns upd_done 10 cycles after its req. Expected:
   - upd_req sequence 0001, 0010, 0100, 1000, each high 11 cycles.
   - frame_done pulses once and frame_cnt=1.
   - No errors.
2. en=4'b0101. Expected:
   - Only clients 0 and 2 are granted, back to back.
   - Changing en to 4'b1111 mid-WAIT does not add clients until the next frame.
3. en=4'b0011, client 0 never responds. Expected:
   - upd_req[0] stays high exactly 4096 cycles, then timeout_err=4'b0001.
   - Client 1 is granted next and frame_done pulses.
   - Pulsing clr_err clears timeout_err to 0.
4. Shortened vblnk (50 cycles), en=4'b0001, no done. Expected:
   - upd_req drops the cycle after vblnk falls.
   - overrun=1 and no frame_done.
   - Next rise restarts from client 0 with frame_cnt incremented.
5. en=0. Expected:
   - frame_done pulses the cycle after the rise and upd_req never asserts.
   - Run 65537 frames with preloaded frame_cnt=16'hFFFF: frame_cnt wraps to 0.
6. Assert rst_n=0 while upd_req=0010. Expected:
   - All outputs go to reset values without waiting for a clock edge.
   - After release, nothing is granted until a fresh vblnk rise.
